traffic_phase_seq: RTL and testbench



---
 rtl/traffic_phase_seq_if.sv | 28 ++
 rtl/traffic_phase_seq.sv | 203 ++++++++++++++++++++
 tb/tb_traffic_phase_seq.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_seq_if.sv
// Pin bundle for the traffic phase sequencer: mode/config buttons and demand
// pulses in, RGB lights, countdown, active way and pending demands out.
interface traffic_phase_seq_if #(
  parameter int N_WAY = 2,
  parameter int CNT_W = 4,
  parameter int WAY_W = (N_WAY > 1) ? $clog2(N_WAY) : 1
);
  logic [1:0]         mode_i;
  logic [1:0]         cfg_sel_i;
  logic               inc_i;
  logic               dec_i;
  logic               def_i;
  logic [N_WAY-1:0]   ped_req_i;
  logic [3*N_WAY-1:0] light_o;
  logic [CNT_W-1:0]   cnt_o;
  logic [WAY_W-1:0]   way_o;
  logic [N_WAY-1:0]   ped_pend_o;

  modport master (
    output mode_i, cfg_sel_i, inc_i, dec_i, def_i, ped_req_i,
    input  light_o, cnt_o, way_o, ped_pend_o
  );

  modport slave (
    input  mode_i, cfg_sel_i, inc_i, dec_i, def_i, ped_req_i,
    output light_o, cnt_o, way_o, ped_pend_o
  );
endinterface

// File: rtl/traffic_phase_seq.sv
// N-way traffic-light phase sequencer on the 1 Hz tick clock.
// Rotates GREEN/YELLOW/ALLRED per way, with a config mode to edit phase
// lengths, a flashing-yellow mode and demand-driven green gap-out.
module traffic_phase_seq #(
  parameter int N_WAY     = 2,
  parameter int CNT_W     = 4,
  parameter int G_DEF     = 5,
  parameter int Y_DEF     = 1,
  parameter int R_DEF     = 1,
  parameter int MIN_GREEN = 2,
  parameter int WAY_W     = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
  input  logic               div_clk,
  input  logic               rst,
  traffic_phase_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_CONFIG, S_FLASH
  } state_e;

  localparam logic [2:0] C_RED    = 3'b100;
  localparam logic [2:0] C_GREEN  = 3'b010;
  localparam logic [2:0] C_YELLOW = 3'b110;
  localparam logic [2:0] C_BLUE   = 3'b001;
  localparam logic [2:0] C_WHITE  = 3'b111;
  localparam logic [2:0] C_OFF    = 3'b000;

  localparam logic [CNT_W-1:0] LEN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] G_LEN0   = CNT_W'(G_DEF);
  localparam logic [CNT_W-1:0] Y_LEN0   = CNT_W'(Y_DEF);
  localparam logic [CNT_W-1:0] R_LEN0   = CNT_W'(R_DEF);
  localparam logic [CNT_W-1:0] MIN_G    = CNT_W'(MIN_GREEN);
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(N_WAY - 1);

  state_e             state_q, state_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   g_len_q, g_len_d;
  logic [CNT_W-1:0]   y_len_q, y_len_d;
  logic [CNT_W-1:0]   r_len_q, r_len_d;
  logic [N_WAY-1:0]   pend_q, pend_d;
  logic               flash_q, flash_d;

  logic               cfg_mode, flash_mode;
  logic [CNT_W-1:0]   sel_len, sel_def, new_len;
  logic [N_WAY-1:0]   way_oh;
  logic               gap_out;
  logic [N_WAY-1:0][2:0] light_w;
  logic [CNT_W-1:0]   cnt_out;

  assign cfg_mode   = (bus.mode_i == 2'b01);
  assign flash_mode = bus.mode_i[1];

  // State register: async reset also restores the phase lengths.
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      way_q   <= '0;
      cnt_q   <= '0;
      g_len_q <= G_LEN0;
      y_len_q <= Y_LEN0;
      r_len_q <= R_LEN0;
      pend_q  <= '0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      g_len_q <= g_len_d;
      y_len_q <= y_len_d;
      r_len_q <= r_len_d;
      pend_q  <= pend_d;
      flash_q <= flash_d;
    end
  end

  // Length editing: inc > dec > def on the selected register, config edges only.
  always_comb begin
    g_len_d = g_len_q;
    y_len_d = y_len_q;
    r_len_d = r_len_q;
    case (bus.cfg_sel_i)
      2'd0:    begin sel_len = g_len_q; sel_def = G_LEN0; end
      2'd1:    begin sel_len = y_len_q; sel_def = Y_LEN0; end
      default: begin sel_len = r_len_q; sel_def = R_LEN0; end
    endcase
    new_len = sel_len;
    if (bus.inc_i)
      new_len = (sel_len == LEN_MAX) ? sel_len : sel_len + LEN_ONE;
    else if (bus.dec_i)
      new_len = (sel_len <= LEN_ONE) ? LEN_ONE : sel_len - LEN_ONE;
    else if (bus.def_i)
      new_len = sel_def;
    if (cfg_mode) begin
      case (bus.cfg_sel_i)
        2'd0:    g_len_d = new_len;
        2'd1:    y_len_d = new_len;
        2'd2:    r_len_d = new_len;
        default: ;
      endcase
    end
  end

  // Next state: mode override first, then phase advance, gap-out, countdown.
  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    pend_d  = pend_q | bus.ped_req_i;
    way_oh  = '0;
    way_oh[way_q] = 1'b1;
    // A demand arriving this edge already counts toward gap-out.
    gap_out = (|((pend_q | bus.ped_req_i) & ~way_oh)) && (cnt_q > MIN_G);
    if (cfg_mode) begin
      state_d = S_CONFIG;
    end else if (flash_mode) begin
      state_d = S_FLASH;
      flash_d = (state_q == S_FLASH) ? ~flash_q : 1'b1;
    end else begin
      case (state_q)
        S_GREEN: begin
          if (cnt_q <= LEN_ONE) begin
            state_d = S_YELLOW;
            cnt_d   = y_len_q;
          end else if (gap_out) begin
            cnt_d = MIN_G;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
          end
        end
        S_YELLOW: begin
          if (cnt_q <= LEN_ONE) begin
            state_d = S_ALLRED;
            cnt_d   = r_len_q;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
          end
        end
        S_ALLRED: begin
          if (cnt_q <= LEN_ONE) begin
            state_d = S_GREEN;
            way_d   = (way_q == WAY_LAST) ? '0 : way_q + WAY_W'(1);
            cnt_d   = g_len_q;
            pend_d[way_d] = 1'b0;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
          end
        end
        // IDLE, CONFIG and FLASH all restart the run at GREEN(0).
        default: begin
          state_d   = S_GREEN;
          way_d     = '0;
          cnt_d     = g_len_q;
          pend_d[0] = 1'b0;
        end
      endcase
    end
  end

  // Output decode from registered state (config lights/count follow cfg_sel_i).
  always_comb begin
    cnt_out = '0;
    for (int k = 0; k < N_WAY; k++) begin
      light_w[k] = C_BLUE;
      case (state_q)
        S_GREEN:  light_w[k] = (WAY_W'(k) == way_q) ? C_GREEN  : C_RED;
        S_YELLOW: light_w[k] = (WAY_W'(k) == way_q) ? C_YELLOW : C_RED;
        S_ALLRED: light_w[k] = C_RED;
        S_FLASH:  light_w[k] = flash_q ? C_YELLOW : C_OFF;
        S_CONFIG: begin
          case (bus.cfg_sel_i)
            2'd0:    light_w[k] = (k == 0) ? C_GREEN : C_RED;
            2'd1:    light_w[k] = C_YELLOW;
            2'd2:    light_w[k] = C_WHITE;
            default: light_w[k] = C_BLUE;
          endcase
        end
        default:  light_w[k] = C_BLUE;
      endcase
    end
    case (state_q)
      S_GREEN, S_YELLOW, S_ALLRED: cnt_out = cnt_q;
      S_CONFIG: begin
        case (bus.cfg_sel_i)
          2'd0:    cnt_out = g_len_q;
          2'd1:    cnt_out = y_len_q;
          2'd2:    cnt_out = r_len_q;
          default: cnt_out = '0;
        endcase
      end
      default: cnt_out = '0;
    endcase
  end

  assign bus.light_o    = light_w;
  assign bus.cnt_o      = cnt_out;
  assign bus.way_o      = way_q;
  assign bus.ped_pend_o = pend_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Bench for traffic_phase_seq: a 2-way/4-bit and a 3-way/5-bit instance share
// one stimulus stream; a behavioural model predicts both every tick.
module tb_traffic_phase_seq;

  localparam int K_IDLE = 0, K_RUN = 1, K_CFG = 2, K_FL = 3;
  localparam int MIN_G  = 2;

  logic       div_clk = 1'b0;
  logic       rst;
  logic [1:0] mode, sel;
  logic       inc, dec, df;
  logic [1:0] req2;
  logic [2:0] req3;

  int nvec = 0;
  int nerr = 0;

  // model state per instance: 0 -> N_WAY=2/CNT_W=4, 1 -> N_WAY=3/CNT_W=5
  int n_w[2]   = '{2, 3};
  int lmax[2]  = '{15, 31};
  int defv[3]  = '{5, 1, 1};
  int m_kind[2];
  int m_ph[2];      // 0 green, 1 yellow, 2 all-red
  int m_way[2];
  int m_cnt[2];
  int m_len[2][3];
  int m_pend[2];
  int m_fl[2];

  int exp_cnt[14] = '{5, 4, 3, 2, 1, 1, 1, 5, 4, 3, 2, 1, 1, 1};

  traffic_phase_seq_if #(.N_WAY(2), .CNT_W(4), .WAY_W(1)) bus2 ();
  traffic_phase_seq_if #(.N_WAY(3), .CNT_W(5), .WAY_W(2)) bus3 ();

  assign bus2.mode_i = mode;  assign bus3.mode_i = mode;
  assign bus2.cfg_sel_i = sel; assign bus3.cfg_sel_i = sel;
  assign bus2.inc_i = inc;    assign bus3.inc_i = inc;
  assign bus2.dec_i = dec;    assign bus3.dec_i = dec;
  assign bus2.def_i = df;     assign bus3.def_i = df;
  assign bus2.ped_req_i = req2;
  assign bus3.ped_req_i = req3;

  traffic_phase_seq #(.N_WAY(2)) dut2 (.div_clk(div_clk), .rst(rst), .bus(bus2.slave));
  traffic_phase_seq #(.N_WAY(3), .CNT_W(5)) dut3 (.div_clk(div_clk), .rst(rst), .bus(bus3.slave));

  always #5 div_clk = ~div_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = K_IDLE; m_ph[i] = 0; m_way[i] = 0; m_cnt[i] = 0;
      m_pend[i] = 0; m_fl[i] = 0;
      for (int p = 0; p < 3; p++) m_len[i][p] = defv[p];
    end
  endtask

  // One tick of the rules: mode override, else run-phase rotation.
  task automatic m_step(input int i, input int md, input int sl,
                        input bit pi, input bit pd, input bit pf, input int rq);
    int pend_n;
    pend_n = m_pend[i] | rq;
    if (md == 1) begin
      if (sl < 3) begin
        if (pi)      m_len[i][sl] = (m_len[i][sl] + 1 > lmax[i]) ? lmax[i] : m_len[i][sl] + 1;
        else if (pd) m_len[i][sl] = (m_len[i][sl] - 1 < 1) ? 1 : m_len[i][sl] - 1;
        else if (pf) m_len[i][sl] = defv[sl];
      end
      m_kind[i] = K_CFG;
    end else if (md >= 2) begin
      m_fl[i] = (m_kind[i] == K_FL) ? !m_fl[i] : 1;
      m_kind[i] = K_FL;
    end else if (m_kind[i] != K_RUN) begin
      m_kind[i] = K_RUN; m_ph[i] = 0; m_way[i] = 0;
      m_cnt[i] = m_len[i][0];
      pend_n &= ~1;
    end else if (m_cnt[i] <= 1) begin
      m_ph[i] = (m_ph[i] + 1) % 3;
      if (m_ph[i] == 0) begin
        m_way[i] = (m_way[i] + 1) % n_w[i];
        pend_n &= ~(1 << m_way[i]);
      end
      m_cnt[i] = m_len[i][m_ph[i]];
    end else if (m_ph[i] == 0 && ((m_pend[i] | rq) & ~(1 << m_way[i])) != 0 && m_cnt[i] > MIN_G) begin
      m_cnt[i] = MIN_G;
    end else begin
      m_cnt[i] = m_cnt[i] - 1;
    end
    m_pend[i] = pend_n;
  endtask

  function automatic logic [31:0] m_light(input int i, input int sl);
    logic [31:0] l;
    logic [2:0]  c;
    l = '0;
    for (int k = 0; k < n_w[i]; k++) begin
      case (m_kind[i])
        K_RUN: begin
          if (m_ph[i] == 2 || k != m_way[i]) c = 3'b100;
          else c = (m_ph[i] == 0) ? 3'b010 : 3'b110;
        end
        K_CFG: begin
          case (sl)
            0:       c = (k == 0) ? 3'b010 : 3'b100;
            1:       c = 3'b110;
            2:       c = 3'b111;
            default: c = 3'b001;
          endcase
        end
        K_FL:    c = m_fl[i] ? 3'b110 : 3'b000;
        default: c = 3'b001;
      endcase
      l[3*k +: 3] = c;
    end
    return l;
  endfunction

  function automatic int m_cnt_o(input int i, input int sl);
    if (m_kind[i] == K_RUN) return m_cnt[i];
    if (m_kind[i] == K_CFG) return (sl < 3) ? m_len[i][sl] : 0;
    return 0;
  endfunction

  // Model advances with the DUTs on the same edge, resets with them.
  always @(posedge div_clk or posedge rst) begin
    if (rst) m_reset();
    else begin
      m_step(0, int'(mode), int'(sel), inc, dec, df, int'(req2));
      m_step(1, int'(mode), int'(sel), inc, dec, df, int'(req3));
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(posedge div_clk) begin
    #2;
    chk("light2", 32'(bus2.light_o), m_light(0, int'(sel)));
    chk("cnt2",   32'(bus2.cnt_o),   32'(m_cnt_o(0, int'(sel))));
    chk("way2",   32'(bus2.way_o),   32'(m_way[0]));
    chk("pend2",  32'(bus2.ped_pend_o), 32'(m_pend[0]));
    chk("light3", 32'(bus3.light_o), m_light(1, int'(sel)));
    chk("cnt3",   32'(bus3.cnt_o),   32'(m_cnt_o(1, int'(sel))));
    chk("way3",   32'(bus3.way_o),   32'(m_way[1]));
    chk("pend3",  32'(bus3.ped_pend_o), 32'(m_pend[1]));
  end

  task automatic tick();
    @(posedge div_clk);
    #3;
  endtask

  task automatic pulse(input int n, input bit pi, input bit pd, input bit pf);
    for (int j = 0; j < n; j++) begin
      inc = pi; dec = pd; df = pf;
      tick();
    end
    inc = 0; dec = 0; df = 0;
  endtask

  initial begin
    mode = 2'b00; sel = 2'd0; inc = 0; dec = 0; df = 0;
    req2 = '0; req3 = '0; rst = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    // IDLE before the first edge
    chk("idle_light2", 32'(bus2.light_o), 32'h09);
    chk("idle_light3", 32'(bus3.light_o), 32'h49);
    chk("idle_cnt2",   32'(bus2.cnt_o), 32'd0);

    // default run: 14-tick cycle on two ways, way wrap on three
    for (int t = 1; t <= 22; t++) begin
      tick();
      chk("run_cnt2", 32'(bus2.cnt_o), 32'(exp_cnt[(t - 1) % 14]));
      chk("run_way2", 32'(bus2.way_o), (((t - 1) % 14) < 7) ? 32'd0 : 32'd1);
      if (t == 1)  chk("g0_light2", 32'(bus2.light_o), 32'b100_010);
      if (t == 6)  chk("y0_light2", 32'(bus2.light_o), 32'b100_110);
      if (t == 7)  chk("r0_light2", 32'(bus2.light_o), 32'b100_100);
      if (t == 8)  chk("g1_light2", 32'(bus2.light_o), 32'b010_100);
      if (t == 1)  chk("wrap_way3", 32'(bus3.way_o), 32'd0);
      if (t == 8)  chk("wrap_way3", 32'(bus3.way_o), 32'd1);
      if (t == 15) chk("wrap_way3", 32'(bus3.way_o), 32'd2);
      if (t == 22) chk("wrap_way3", 32'(bus3.way_o), 32'd0);
    end

    // config saturation
    mode = 2'b01; sel = 2'd1;
    tick();
    chk("cfg_y_cnt2",   32'(bus2.cnt_o), 32'd1);
    chk("cfg_y_light2", 32'(bus2.light_o), 32'b110_110);
    pulse(20, 1, 0, 0);
    chk("y_inc_sat2", 32'(bus2.cnt_o), 32'd15);
    chk("y_inc3",     32'(bus3.cnt_o), 32'd21);
    pulse(20, 0, 1, 0);
    chk("y_dec_sat2", 32'(bus2.cnt_o), 32'd1);
    chk("y_dec_sat3", 32'(bus3.cnt_o), 32'd1);
    pulse(1, 0, 0, 1);
    chk("y_def2", 32'(bus2.cnt_o), 32'd1);
    sel = 2'd2; #1;
    chk("cfg_r_light2", 32'(bus2.light_o), 32'b111_111);
    sel = 2'd3; #1;
    chk("cfg_n_cnt2", 32'(bus2.cnt_o), 32'd0);
    pulse(2, 1, 0, 0);
    sel = 2'd0; #1;
    chk("cfg_g_light2", 32'(bus2.light_o), 32'b100_010);
    pulse(1, 1, 1, 0);
    chk("g_incdec2", 32'(bus2.cnt_o), 32'd6);
    pulse(30, 1, 0, 0);
    chk("g_sat2", 32'(bus2.cnt_o), 32'd15);
    chk("g_sat3", 32'(bus3.cnt_o), 32'd31);

    // async reset mid-config
    rst = 1'b1; #1;
    chk("arst_light2", 32'(bus2.light_o), 32'h09);
    chk("arst_cnt2",   32'(bus2.cnt_o), 32'd0);
    chk("arst_way2",   32'(bus2.way_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_g2", 32'(bus2.cnt_o), 32'd5);
    chk("arst_g3", 32'(bus3.cnt_o), 32'd5);
    sel = 2'd1; #1;
    chk("arst_y3", 32'(bus3.cnt_o), 32'd1);

    // gap-out
    mode = 2'b00; sel = 2'd0;
    tick();
    chk("gap_entry2", 32'(bus2.cnt_o), 32'd5);
    req2 = 2'b10;
    tick();
    req2 = 2'b00;
    chk("gap_cnt2",  32'(bus2.cnt_o), 32'd2);
    chk("gap_pend2", 32'(bus2.ped_pend_o), 32'b10);
    tick(); tick(); tick(); tick();
    chk("g1_way2",  32'(bus2.way_o), 32'd1);
    chk("g1_cnt2",  32'(bus2.cnt_o), 32'd5);
    chk("g1_pend2", 32'(bus2.ped_pend_o), 32'b00);
    tick(); tick(); tick();
    chk("g1_cnt2b", 32'(bus2.cnt_o), 32'd2);
    req2 = 2'b01;
    tick();
    req2 = 2'b00;
    chk("nogap_cnt2",  32'(bus2.cnt_o), 32'd1);
    chk("nogap_pend2", 32'(bus2.ped_pend_o), 32'b01);
    tick();
    chk("y1_light2", 32'(bus2.light_o), 32'b110_100);

    // flash from mid-yellow, then back to run
    mode = 2'b10;
    tick();
    chk("fl_on2",  32'(bus2.light_o), 32'b110_110);
    chk("fl_cnt2", 32'(bus2.cnt_o), 32'd0);
    chk("fl_way2", 32'(bus2.way_o), 32'd1);
    tick();
    chk("fl_off2", 32'(bus2.light_o), 32'd0);
    tick();
    chk("fl_on2b", 32'(bus2.light_o), 32'b110_110);
    mode = 2'b00;
    tick();
    chk("fl_ret_cnt2",  32'(bus2.cnt_o), 32'd5);
    chk("fl_ret_way2",  32'(bus2.way_o), 32'd0);
    chk("fl_ret_pend2", 32'(bus2.ped_pend_o), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      int r;
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 5);
        mode = (r < 3) ? 2'b00 : 2'(r - 2);
      end
      if ($urandom_range(0, 4) == 0) sel = 2'($urandom_range(0, 3));
      inc = ($urandom_range(0, 6) == 0);
      dec = ($urandom_range(0, 6) == 0);
      df  = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 2; k++) req2[k] = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 3; k++) req3[k] = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; inc = 0; dec = 0; df = 0; req2 = '0; req3 = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
